// File: rtl/pe_sum_deskew.sv
// pe_sum_deskew: realigns skewed PE-array column sums into whole rows and queues them in a show-ahead FIFO
module pe_sum_deskew #(
  parameter int NUM   = 16,
  parameter int DEPTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_sum_valid,
  input  logic [NUM*32-1:0]     i_in_sum,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [NUM*32-1:0]     o_out_data,
  output logic [$clog2(DEPTH):0] o_out_count,
  output logic                  o_full,
  output logic                  o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] CFULL = DEPTH[AW:0];
  logic [NUM*32-1:0] w_row;
  logic              w_aligned_valid, w_push, w_pop, w_wr;
  logic [NUM*32-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_overflow;
  for (genvar j = 0; j < NUM; j++) begin : g_lane
    localparam int D = NUM - 1 - j;
    if (D == 0) begin : g_pass
      assign w_row[j*32 +: 32] = i_in_sum[j*32 +: 32];
    end else begin : g_dl
      logic [31:0] r_dl [D];
      always_ff @(posedge i_clk)
        if (i_rst) r_dl <= '{default: '0};
        else if (i_en) begin
          r_dl[0] <= i_in_sum[j*32 +: 32];
          for (int k = 1; k < D; k++) r_dl[k] <= r_dl[k-1];
        end
      assign w_row[j*32 +: 32] = r_dl[D-1];
    end
  end
  if (NUM == 1) begin : g_v0
    assign w_aligned_valid = i_sum_valid;
  end else begin : g_vl
    localparam int VW = NUM - 1;
    logic [VW-1:0] r_vl;
    always_ff @(posedge i_clk)
      if (i_rst) r_vl <= '0;
      else if (i_en) r_vl <= (r_vl << 1) | VW'(i_sum_valid);
    assign w_aligned_valid = r_vl[VW-1];
  end
  assign w_push      = w_aligned_valid & i_en;
  assign o_out_valid = r_count != '0;
  assign o_full      = r_count == CFULL;
  assign w_pop       = o_out_valid & i_out_ready;
  assign w_wr        = w_push & (~o_full | w_pop);
  assign o_out_data  = o_out_valid ? r_mem[r_rd_ptr] : '0;
  assign o_out_count = r_count;
  assign o_overflow  = r_overflow;
  always_ff @(posedge i_clk)
    if (w_wr) r_mem[r_wr_ptr] <= w_row;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count    <= r_count + CW'(w_wr) - CW'(w_pop);
      r_overflow <= r_overflow | (w_push & o_full & ~w_pop);
    end
endmodule

// File: tb/tb_pe_sum_deskew.sv
// tb_pe_sum_deskew: randomized and directed checks of pe_sum_deskew against a queue-based row model
module tb_pe_sum_deskew;
  localparam int NUM = 4;
  localparam int DEPTH = 4;
  localparam int W = NUM * 32;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HL = 1024;
  logic clk = 1'b0;
  logic rst, en, sv, rdy;
  logic [W-1:0] sum;
  logic o_valid, o_full, o_ovf;
  logic [W-1:0] o_data;
  logic [CW-1:0] o_cnt;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] h_sum [HL];
  bit h_sv [HL];
  int ecnt = 0;
  logic [W-1:0] q [$];
  bit m_ovf = 1'b0;

  pe_sum_deskew #(.NUM(NUM), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_sum_valid(sv), .i_in_sum(sum),
    .o_out_valid(o_valid), .i_out_ready(rdy), .o_out_data(o_data),
    .o_out_count(o_cnt), .o_full(o_full), .o_overflow(o_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // lane j at call k belongs to row k-j of a back-to-back burst of nrows rows; each lane of row n carries base+n
  function automatic logic [W-1:0] rowstim(int k, int nrows, int base);
    logic [W-1:0] s = rnd();
    for (int j = 0; j < NUM; j++)
      if (k - j >= 0 && k - j < nrows) s[j*32 +: 32] = 32'(base + k - j);
    return s;
  endfunction

  // Model: a row whose sum_valid arrived on EN-high cycle e takes lane j from EN-high cycle e+j
  // and enters the FIFO queue on EN-high cycle e+NUM-1.
  task automatic cyc(input bit r, input bit e, input bit v, input logic [W-1:0] s, input bit rd);
    bit pop, push;
    logic [W-1:0] row;
    rst = r; en = e; sv = v; sum = s; rdy = rd;
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
      ecnt = 0;
      for (int i = 0; i < HL; i++) h_sv[i] = 1'b0;
    end else begin
      pop = q.size() != 0 && rd;
      push = 1'b0;
      if (e) begin
        h_sum[ecnt % HL] = s;
        h_sv[ecnt % HL] = v;
        if (ecnt >= NUM - 1 && h_sv[(ecnt - NUM + 1) % HL]) begin
          push = 1'b1;
          for (int j = 0; j < NUM; j++) row[j*32 +: 32] = h_sum[(ecnt - NUM + 1 + j) % HL][j*32 +: 32];
        end
        ecnt++;
      end
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) q.push_back(row);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, '0, 0);
    cyc(1, 1, 1, rnd(), 1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
    checks++; if (o_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", o_data); end
    checks++; if (o_cnt !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", o_cnt); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", o_full); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", o_ovf); end
  endtask

  task automatic test_latency();
    int first = -1;
    logic [W-1:0] d = '0;
    logic [W-1:0] exp_row = {32'h103, 32'h102, 32'h101, 32'h100};
    logic [W-1:0] s;
    for (int k = 0; k < 4; k++) begin
      s = rnd();
      s[k*32 +: 32] = 32'h100 + 32'(k);
      cyc(0, 1, k == 0, s, 1);
      if (o_valid && first < 0) begin first = k + 1; d = o_data; end
    end
    checks++; if (first !== 4) begin errors++; $display("FAIL latency_cycle got %0d exp 4", first); end
    checks++; if (d !== exp_row) begin errors++; $display("FAIL latency_data got %h exp %h", d, exp_row); end
    cyc(0, 1, 0, rnd(), 1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL latency_fall got %b exp 0", o_valid); end
  endtask

  task automatic test_en_stall();
    int first = -1;
    int lane = 0;
    logic [W-1:0] d = '0;
    logic [W-1:0] exp_row = {32'h103, 32'h102, 32'h101, 32'h100};
    logic [W-1:0] s;
    bit e;
    for (int k = 0; k < 8; k++) begin
      e = !(k == 1 || k == 2);
      s = rnd();
      if (e && lane < 4) begin s[lane*32 +: 32] = 32'h100 + 32'(lane); lane++; end
      cyc(0, e, k == 0, s, 1);
      if (o_valid && first < 0) begin first = k + 1; d = o_data; end
    end
    checks++; if (first !== 6) begin errors++; $display("FAIL stall_cycle got %0d exp 6", first); end
    checks++; if (d !== exp_row) begin errors++; $display("FAIL stall_data got %h exp %h", d, exp_row); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] e;
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, k < 5, rowstim(k, 5, 0), 0);
      if (k == 6) begin
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", o_ovf); end
      end
    end
    checks++; if (o_cnt !== CW'(4)) begin errors++; $display("FAIL ovf_count got %0d exp 4", o_cnt); end
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", o_full); end
    checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", o_ovf); end
    for (int n = 0; n < 4; n++) begin
      e = {4{32'(n)}};
      checks++; if (o_data !== e) begin errors++; $display("FAIL ovf_drain%0d got %h exp %h", n, o_data, e); end
      cyc(0, 1, 0, rnd(), 1);
    end
    checks++; if (o_valid !== 1'b0 || o_cnt !== '0) begin errors++; $display("FAIL ovf_empty got v=%b c=%0d exp v=0 c=0", o_valid, o_cnt); end
    checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", o_ovf); end
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 5; k++) cyc(0, 1, k == 0 || k == 1 || k == 3 || k == 4, rnd(), 0);
    checks++; if (o_cnt !== CW'(2)) begin errors++; $display("FAIL mid_queued got %0d exp 2", o_cnt); end
    cyc(1, 1, 1, rnd(), 0);
    checks++; if (o_valid !== 1'b0 || o_cnt !== '0 || o_data !== '0 || o_ovf !== 1'b0)
      begin errors++; $display("FAIL mid_reset got v=%b c=%0d d=%h o=%b exp all 0", o_valid, o_cnt, o_data, o_ovf); end
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, 0, rnd(), 1);
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_stale%0d got %b exp 0", k, o_valid); end
    end
  endtask

  task automatic test_full_pushpop();
    logic [W-1:0] e;
    cyc(1, 0, 0, '0, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, k < 5, rowstim(k, 5, 16), k == 7);
      if (k == 6) begin
        checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL pp_full got %b exp 1", o_full); end
      end
    end
    checks++; if (o_cnt !== CW'(4) || o_full !== 1'b1) begin errors++; $display("FAIL pp_count got %0d/%b exp 4/1", o_cnt, o_full); end
    checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL pp_overflow got %b exp 0", o_ovf); end
    for (int n = 1; n < 5; n++) begin
      e = {4{32'(16 + n)}};
      checks++; if (o_data !== e) begin errors++; $display("FAIL pp_drain%0d got %h exp %h", n, o_data, e); end
      cyc(0, 1, 0, rnd(), 1);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int run = 0;
    int maxc = 0;
    logic [W-1:0] e;
    cyc(1, 0, 0, '0, 0);
    for (int k = 0; k < 14; k++) begin
      cyc(0, 1, k < 8, rnd(), 1);
      e = q.size() != 0 ? q[0] : '0;
      checks++; if (o_valid !== (q.size() != 0) || o_data !== e)
        begin errors++; $display("FAIL b2b_row%0d got v=%b d=%h exp v=%b d=%h", k, o_valid, o_data, q.size() != 0, e); end
      if (o_valid) begin if (first < 0) first = k + 1; run++; end
      if (int'(o_cnt) > maxc) maxc = int'(o_cnt);
    end
    checks++; if (first !== 4 || run !== 8) begin errors++; $display("FAIL b2b_run got start=%0d len=%0d exp 4/8", first, run); end
    checks++; if (maxc > 1) begin errors++; $display("FAIL b2b_maxcount got %0d exp <=1", maxc); end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rnd(),
          $urandom_range(0, 9) < 6);
      e = q.size() != 0 ? q[0] : '0;
      checks++;
      if (o_valid !== (q.size() != 0) || o_data !== e || o_cnt !== CW'(q.size()) ||
          o_full !== (q.size() == DEPTH) || o_ovf !== m_ovf)
        begin errors++; $display("FAIL rand%0d got v=%b c=%0d f=%b o=%b d=%h exp v=%b c=%0d f=%b o=%b d=%h",
          k, o_valid, o_cnt, o_full, o_ovf, o_data, q.size() != 0, q.size(), q.size() == DEPTH, m_ovf, e); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sv = 1'b0; sum = '0; rdy = 1'b0;
    test_reset();
    test_latency();
    test_en_stall();
    test_overflow();
    test_reset_midflight();
    test_full_pushpop();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_sum_deskew.md
# pe_sum_deskew

Output stage directly downstream of the systolic PE array. Each array column's partial-sum result leaves the bottom row one cycle after the column to its left. This block re-aligns those skewed column results into whole result rows. It queues the rows in a FIFO and hands them to the writeback/buffer stage over a valid/ready handshake.

## Interface
- NUM, 16, number of PE columns (32-bit lanes); must be ≥ 1
- DEPTH, 8, FIFO entries, power of two, ≥ 2
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- EN  in  1  array advance enable; same signal that drives the PE array EN
- sum_valid  in  1  asserted in the cycle column 0 of a result row appears on in_sum
- in_sum  in  NUM*32  bottom-row sums from the array; lane j = bits [(j+1)*32-1 : j*32]
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  NUM*32  aligned result row at FIFO head; all-zero when out_valid=0
- out_count  out  $clog2(DEPTH)+1  rows currently held
- full  out  1  out_count == DEPTH
- overflow  out  1  sticky; a row was dropped because the FIFO was full

## Operation
- Deskew: lane j passes through an EN-qualified delay line of NUM-1-j registers. Lane NUM-1 has no delay.
- sum_valid passes through its own NUM-1-stage delay line, also EN-qualified.
- With EN=0, no delay register shifts and sum_valid is ignored; the delay lines hold their contents.
- Aligned row: lane j's delay-line output plus the delayed valid (aligned_valid).
- Push: aligned_valid && EN.
- Pop: out_valid && out_ready. Pop is independent of EN and never blocked by EN.
- Push with FIFO not full: the row is written at wr_ptr, wr_ptr advances, out_count increments.
- Push while full and no pop this cycle: the row is dropped, overflow is set, pointers and count are unchanged.
- Push and pop in the same cycle: both succeed, including when full. A full FIFO with simultaneous push and pop accepts the row and stays full. Count is unchanged.
- Pop while empty: not possible, since out_valid=0.
- Pointers: $clog2(DEPTH) bits and wrap naturally. out_count is kept separately to tell full from empty.
- out_data = mem[rd_ptr] gated by out_valid (show-ahead, no read latency).
- Data is passed through bit-exact. There is no arithmetic and no interpretation of the 32-bit format, so int and float modes are both transparent.
- overflow clears only on RESET.

## Timing
- Reset values: out_valid=0, out_data=0, out_count=0, full=0, overflow=0. Also cleared on reset: all delay-line data registers and valid bits, rd_ptr, wr_ptr.
- RESET mid-operation discards every in-flight and queued row. RESET has priority over push, pop and EN.
- Latency with EN held high: sum_valid in cycle t gives out_valid=1 in cycle t+NUM, or t+NUM+k when the FIFO already held k rows ahead of it.
- Lane j of that row must be on in_sum in cycle t+j. All lanes appear together in out_data from cycle t+NUM.
- Each EN-low cycle during transit delays the row by exactly one cycle. Lanes stay aligned.
- Throughput: one row per cycle in and one row per cycle out, sustained.
- full and out_count change only at the clock edge after a push or pop.
- NUM=1: no delay registers; latency is 1 cycle.

## Test plan
- NUM=4, DEPTH=4. After reset, hold EN=1 and pulse sum_valid in cycle 10. Drive lane j = 0x100+j in cycle 10+j. Expected: out_valid rises in cycle 14 with out_data = {0x103,0x102,0x101,0x100} (lane 3 at the MSBs). With out_ready=1, out_valid falls in cycle 15.
- Same row with EN=0 in cycles 11 and 12. Expected: out_valid rises in cycle 16 with identical data, and no lane is misaligned.
- out_ready=0; push 5 rows, with row n carrying lane value n. Expected: out_count reaches 4, full=1, the 5th row is dropped and overflow=1. Draining returns rows 0,1,2,3 in order; overflow stays 1.
- FIFO full, out_ready=1, a new row pushed in the same cycle. Expected: the head is popped and the new row accepted, out_count stays 4, overflow stays 0.
- Rows in flight in the delay lines plus 2 queued, then RESET for one cycle. Expected: next cycle out_valid=0, out_count=0, out_data=0, overflow=0. No stale row ever emerges afterwards.
- Back-to-back sum_valid for 8 cycles with out_ready=1. Expected: 8 consecutive out_valid cycles starting at cycle t+4, each row correct, out_count never exceeds 1.
